// File: rtl/i2s_clock_controller.sv
// I2S bit-clock and word-select generator. Frames always finish cleanly; a stop
// request only takes effect at the next left-slot boundary.
module i2s_clock_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                 S_AXIS_ACLK,
    input  logic                 S_AXIS_ARESETN,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] clk_div,
    output logic                 sck,
    output logic                 ws,
    output logic                 running,
    output logic                 frame_start
);
    localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] hcnt;
    logic [BW-1:0]        bcnt;

    logic half_done, fall, wrap, boundary;

    always_comb begin
        half_done = (hcnt == div_q);
        fall      = half_done & sck;
        wrap      = fall & (bcnt == BIT_LAST);
        boundary  = wrap & ws;
    end

    assign running = (state != IDLE);

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state       <= IDLE;
            sck         <= 1'b0;
            ws          <= 1'b0;
            frame_start <= 1'b0;
            div_q       <= '0;
            hcnt        <= '0;
            bcnt        <= '0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    sck  <= 1'b0;
                    ws   <= 1'b0;
                    hcnt <= '0;
                    bcnt <= '0;
                    if (enable) begin
                        state       <= RUN;
                        div_q       <= clk_div;
                        frame_start <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    // A re-asserted enable in STOP wins over the boundary, so a
                    // one-cycle enable drop never disturbs the waveform.
                    if (boundary && state == STOP && !enable) begin
                        state <= IDLE;
                        sck   <= 1'b0;
                        ws    <= 1'b0;
                        hcnt  <= '0;
                        bcnt  <= '0;
                    end else begin
                        state <= enable ? RUN : STOP;
                        if (half_done) begin
                            hcnt <= '0;
                            sck  <= ~sck;
                            if (sck) begin
                                if (wrap) begin
                                    bcnt <= '0;
                                    ws   <= ~ws;
                                    if (ws) begin
                                        frame_start <= 1'b1;
                                        div_q       <= clk_div;
                                    end
                                end else begin
                                    bcnt <= bcnt + BW'(1);
                                end
                            end
                        end else begin
                            hcnt <= hcnt + DIV_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_clock_controller.sv
// Scoreboarded bench: a frame-offset reference model predicts every cycle of
// sck/ws/running/frame_start; a negedge monitor compares against the DUT.
module tb_i2s_clock_controller;
    localparam int DW   = 32;
    localparam int DIVW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [DIVW-1:0] clk_div = '0;
    logic            sck, ws, running, frame_start;

    i2s_clock_controller #(.DATA_WIDTH(DW), .DIV_WIDTH(DIVW)) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESETN(rst_n),
        .enable        (enable),
        .clk_div       (clk_div),
        .sck           (sck),
        .ws            (ws),
        .running       (running),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic sck;
        logic ws;
        logic running;
        logic fs;
    } obs_t;

    obs_t q[$];
    int   nvec = 0;
    int   errs = 0;
    bit   mon_en = 1'b0;

    // Model: a frame is 4*DW half-periods of (d+1) cycles; k = cycles since frame start.
    bit m_act = 1'b0;
    bit m_prev_en = 1'b0;
    int m_k, m_d, m_len;

    function automatic obs_t model_out();
        obs_t r;
        int   h;
        r = '0;
        if (m_act) begin
            h         = m_k / (m_d + 1);
            r.sck     = (h % 2) == 1;
            r.ws      = (h / 2) >= DW;
            r.running = 1'b1;
            r.fs      = (m_k == 0);
        end
        return r;
    endfunction

    task automatic model_step(input bit en, input int div);
        if (!m_act) begin
            if (en) begin
                m_act = 1'b1;
                m_k   = 0;
                m_d   = div;
                m_len = 4 * DW * (div + 1);
            end
        end else begin
            m_k++;
            if (m_k == m_len) begin
                // Stop only when enable was low at the previous sample and still is.
                if (!en && !m_prev_en) m_act = 1'b0;
                else begin
                    m_k   = 0;
                    m_d   = div;
                    m_len = 4 * DW * (div + 1);
                end
            end
        end
        m_prev_en = en;
    endtask

    task automatic cyc(input bit en, input int div);
        enable  = en;
        clk_div = div[DIVW-1:0];
        @(posedge clk);
        #1;
        model_step(en, div);
        if (mon_en) q.push_back(model_out());
    endtask

    task automatic check_zero(input string name);
        nvec++;
        if ({sck, ws, running, frame_start} !== 4'b0000) begin
            errs++;
            $display("FAIL %s t=%0t got sck=%b ws=%b run=%b fs=%b exp all 0",
                     name, $time, sck, ws, running, frame_start);
        end
    endtask

    always @(negedge clk) begin
        obs_t e, g;
        if (mon_en && q.size() > 0) begin
            e = q.pop_front();
            g = '{sck: sck, ws: ws, running: running, fs: frame_start};
            nvec++;
            if (g !== e) begin
                errs++;
                $display("FAIL outputs t=%0t got sck=%b ws=%b run=%b fs=%b exp sck=%b ws=%b run=%b fs=%b",
                         $time, g.sck, g.ws, g.running, g.fs, e.sck, e.ws, e.running, e.fs);
            end
        end
    end

    task automatic model_reset();
        m_act     = 1'b0;
        m_prev_en = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        model_reset();

        // Idle with enable low, divider wiggling
        repeat (100) cyc(1'b0, $urandom_range(0, 3));

        // Basic run, clk_div=1
        repeat (600) cyc(1'b1, 1);

        // Graceful stop requested during a left slot
        n = 0;
        while (model_out().ws && n < 600) begin cyc(1'b1, 1); n++; end
        n = 0;
        while (m_act && n < 2000) begin cyc(1'b0, 1); n++; end
        nvec++;
        if (m_act) begin errs++; $display("FAIL graceful_stop timeout still running"); end
        repeat (20) cyc(1'b0, 1);

        // Divider change mid-frame
        repeat (100) cyc(1'b1, 1);
        repeat (1200) cyc(1'b1, 3);

        // Minimum divider with single-cycle enable drops
        for (int i = 0; i < 600; i++) cyc((i % 37) != 5, 0);

        // Randomized enable/divider
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 99) < 93, $urandom_range(0, 3));

        // Reset mid-right-slot
        n = 0;
        while (!(m_act && model_out().ws) && n < 2000) begin cyc(1'b1, 1); n++; end
        mon_en = 1'b0;
        q.delete();
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(posedge clk);
        #1 check_zero("reset_hold");
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        repeat (20) cyc(1'b0, 1);
        repeat (300) cyc(1'b1, 2);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule

// File: doc/i2s_clock_controller.md
I2S_CLOCK_CONTROLLER -- requirements
Module: i2s_clock_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32: number of sck bit periods per channel slot; must be 2 or greater.
REQ-002 Parameter DIV_WIDTH, default 8: width of the clk_div input.
REQ-003 S_AXIS_ACLK  input  1  sole clock; every register is clocked on its rising edge.
REQ-004 S_AXIS_ARESETN  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level request to run; sampled every ACLK cycle.
REQ-006 clk_div  input  DIV_WIDTH  sck half-period minus 1, in ACLK cycles.
REQ-007 sck  output  1  I2S bit clock, registered.
REQ-008 ws  output  1  I2S word select (0 = left, 1 = right), registered.
REQ-009 running  output  1  high in RUN and STOP states.
REQ-010 frame_start  output  1  one-cycle pulse marking the start of a left slot.

Function
REQ-011 The block shall implement a three-state FSM: IDLE, RUN, STOP.
REQ-012 IDLE: sck=0, ws=0; all counters held at 0.
  - enable=1 moves to RUN on the next edge.
  - On that same edge, latch clk_div into div_q and pulse frame_start.
REQ-013 In RUN and STOP, a half-period counter shall count 0..div_q.
  - On reaching div_q: toggle sck and clear the counter.
  - Resulting sck period: 2*(div_q+1) ACLK cycles; duty cycle 50%.
REQ-014 The first sck rise after leaving IDLE shall occur div_q+1 cycles after RUN is entered.
REQ-015 A bit counter (0..DATA_WIDTH-1) shall advance only on edges where sck toggles 1->0, wrapping to 0 after DATA_WIDTH-1.
REQ-016 On the falling-sck edge where the bit counter wraps:
  - toggle ws in the same cycle as sck;
  - result: ws changes while sck falls, once every DATA_WIDTH sck periods.
REQ-017 On each ws 1->0 toggle (frame boundary):
  - pulse frame_start for exactly one cycle, coincident with the ws change;
  - relatch clk_div into div_q.
  - clk_div changes shall take effect at no other time.
REQ-018 RUN with enable=0 shall move to STOP; sck, ws and the counters continue unchanged.
REQ-019 STOP with enable=1 shall return to RUN with no disturbance to sck or ws.
REQ-020 STOP shall move to IDLE at the frame boundary, on the edge where ws would toggle 1->0.
  - sck=0, ws=0, counters cleared on that edge.
  - frame_start shall not pulse on that edge.
REQ-021 If enable deasserts and reasserts in consecutive cycles, the sck/ws waveform shall be identical to enable held high.
REQ-022 clk_div=0 shall be legal (sck period 2 ACLK cycles).
REQ-023 A started frame (left slot plus right slot) shall never be truncated except by reset.

Reset
REQ-024 Assertion of S_AXIS_ARESETN=0 shall immediately and asynchronously force:
  - state=IDLE;
  - sck=0, ws=0, running=0, frame_start=0;
  - div_q=0 and all counters=0.
REQ-025 Reset asserted mid-frame shall abort the frame; after release, operation resumes only via REQ-012.
REQ-026 Deassertion of S_AXIS_ARESETN shall take effect on the next ACLK rising edge.

Verification
REQ-027 Reset then idle: release reset with enable=0 for 100 cycles -> sck=0, ws=0, running=0, frame_start never 1.
REQ-028 Basic run: DATA_WIDTH=32, clk_div=1, enable=1 -> the bench shall see:
  - sck period 4 cycles;
  - ws high for exactly 128 cycles, then low for 128;
  - frame_start every 256 cycles, the first in the cycle RUN is entered.
REQ-029 Graceful stop: deassert enable during the left slot -> that left slot and the following right slot complete, then IDLE with sck=0, ws=0, running=0.
REQ-030 Divider change: switch clk_div from 1 to 3 mid-frame -> period stays 4 until the next ws 1->0 toggle, then becomes 8.
REQ-031 Stop cancel and minimum divider:
  - clk_div=0: sck toggles every cycle.
  - enable pulses low for 1 cycle: waveform unchanged versus enable held high.
  - Reset mid-right-slot: all outputs 0 the same cycle.
